cosim_commit_queue: RTL

// - Captures per-cycle retire events from one hart of the DUT and buffers them in order for the
//   co-simulation checker, which steps the golden model once per popped entry and compares results.
// - Sits between the core retire port (upstream) and the DPI-driven commit checker (downstream).
// - Tags each commit with a sequence number, flags buffer overflow and flags retire stalls (watchdog).
// - Compiled only under `ifdef MEEP_COSIM.

---
 rtl/cosim_commit_queue_pkg.sv | 19 +
 rtl/cosim_commit_queue_if.sv | 34 +++
 rtl/cosim_commit_queue_fifo.sv | 45 ++++
 rtl/cosim_commit_queue.sv | 100 ++++++++++
 4 files changed

// File: rtl/cosim_commit_queue_pkg.sv
// Shared types for the co-simulation commit path; the checker side imports the same package.
package cosim_commit_pkg;
    localparam int CM_XLEN    = 64;
    localparam int CM_SEQ_W   = 32;
    localparam int CM_DEPTH   = 16;
    localparam int CM_TIMEOUT = 4096;

    // seq is held at full width so the checker sees one layout whatever SEQ_W the queue uses
    typedef struct packed {
        logic [CM_XLEN-1:0]  pc;
        logic [31:0]         ins;
        logic [4:0]          dst;
        logic                we;
        logic [CM_XLEN-1:0]  data;
        logic                xcpt;
        logic [CM_XLEN-1:0]  cause;
        logic [CM_SEQ_W-1:0] seq;
    } commit_entry_t;
endpackage

// File: rtl/cosim_commit_queue_if.sv
// Retire-port and checker-port bundle of the commit queue.
interface cosim_commit_queue_if #(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 32
);
    import cosim_commit_pkg::*;

    logic                       cm_valid_i;
    logic [CM_XLEN-1:0]         cm_pc_i;
    logic [31:0]                cm_ins_i;
    logic [4:0]                 cm_dst_i;
    logic                       cm_we_i;
    logic [CM_XLEN-1:0]         cm_data_i;
    logic                       cm_xcpt_i;
    logic [CM_XLEN-1:0]         cm_cause_i;
    logic                       out_valid_o;
    logic                       out_ready_i;
    commit_entry_t              out_entry_o;
    logic [$clog2(DEPTH):0]     occupancy_o;
    logic                       overflow_o;
    logic [SEQ_W-1:0]           drop_cnt_o;
    logic                       stall_o;

    modport master (
        output cm_valid_i, cm_pc_i, cm_ins_i, cm_dst_i, cm_we_i, cm_data_i, cm_xcpt_i, cm_cause_i,
        output out_ready_i,
        input  out_valid_o, out_entry_o, occupancy_o, overflow_o, drop_cnt_o, stall_o
    );
    modport slave (
        input  cm_valid_i, cm_pc_i, cm_ins_i, cm_dst_i, cm_we_i, cm_data_i, cm_xcpt_i, cm_cause_i,
        input  out_ready_i,
        output out_valid_o, out_entry_o, occupancy_o, overflow_o, drop_cnt_o, stall_o
    );
endinterface

// File: rtl/cosim_commit_queue_fifo.sv
// Generic first-word-fall-through FIFO; a push is taken when full if a pop happens the same cycle.
module cosim_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/cosim_commit_queue.sv
// Buffers one hart's retire events for the co-sim checker: seq tagging, drop accounting, retire watchdog.
module cosim_commit_queue #(
    parameter int DEPTH   = 16,
    parameter int SEQ_W   = 32,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk_i,
    input  logic               rst_i,
    cosim_commit_queue_if.slave bus
);
    import cosim_commit_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = $bits(commit_entry_t);

    commit_entry_t    wentry;
    logic [EW-1:0]    wdata, rdata;
    logic [CW-1:0]    count;
    logic             full, empty, pop, push, drop;
    logic [SEQ_W-1:0] seq_q, drop_cnt_q;
    logic             overflow_q;

    assign pop  = !empty && bus.out_ready_i;
    assign push = bus.cm_valid_i && (!full || pop);
    assign drop = bus.cm_valid_i && full && !pop;

    always_comb begin
        wentry       = '0;
        wentry.pc    = bus.cm_pc_i;
        wentry.ins   = bus.cm_ins_i;
        wentry.dst   = bus.cm_dst_i;
        wentry.we    = bus.cm_we_i;
        wentry.data  = bus.cm_data_i;
        wentry.xcpt  = bus.cm_xcpt_i;
        wentry.cause = bus.cm_cause_i;
        wentry.seq   = CM_SEQ_W'(seq_q);
    end
    assign wdata = wentry;

    cosim_sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Dropped events still burn a seq number so the checker sees the loss as a gap
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            if (bus.cm_valid_i) seq_q <= seq_q + SEQ_W'(1);
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + SEQ_W'(1);
            end
        end
    end

    assign bus.out_valid_o = !empty;
    assign bus.out_entry_o = commit_entry_t'(rdata);
    assign bus.occupancy_o = count;
    assign bus.overflow_o  = overflow_q;
    assign bus.drop_cnt_o  = drop_cnt_q;

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int WW = $clog2(TIMEOUT + 1);
            logic [WW-1:0] wd_q, wd_d;
            logic          stall_q;

            always_comb begin
                wd_d = wd_q;
                if (bus.cm_valid_i)             wd_d = '0;
                else if (wd_q != WW'(TIMEOUT))  wd_d = wd_q + WW'(1);
            end

            // stall tracks the next counter value so it rises together with counter==TIMEOUT
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    wd_q    <= '0;
                    stall_q <= 1'b0;
                end else begin
                    wd_q    <= wd_d;
                    stall_q <= (wd_d == WW'(TIMEOUT));
                end
            end
            assign bus.stall_o = stall_q;
        end else begin : g_no_wd
            assign bus.stall_o = 1'b0;
        end
    endgenerate
endmodule
